// File: rtl/bus_pkg.sv
// Shared types and default address map for the CPU data-side interconnect.
// Window hit test is a masked compare against a power-of-two sized window.
package bus_pkg;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ROM,
        SEL_RAM,
        SEL_UART
    } bus_sel_e;

    localparam int unsigned DEF_ADDR_WIDTH = 14;
    localparam logic [31:0] DEF_ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] DEF_RAM_BASE   = 32'h1000_0000;
    localparam logic [31:0] DEF_UART_BASE  = 32'h2000_0000;
    localparam logic [31:0] UART_SIZE      = 32'd16;

    // size must be a power of two and base aligned to it; no wrap-around past base+size
    function automatic logic win_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
        return (addr & ~(size - 32'd1)) == base;
    endfunction

endpackage

// File: rtl/bus_if.sv
// Simple strobe bus: address, read/write strobes, byte mask, write/read data.
// AW sets the address width so the same bundle serves the CPU side and each slave.
interface bus_if #(
    parameter int AW = 32
);
    logic [AW-1:0] addr;
    logic          ren;
    logic          wen;
    logic [3:0]    wmask;
    logic [31:0]   wdata;
    logic [31:0]   rdata;

    modport master (
        output addr, ren, wen, wmask, wdata,
        input  rdata
    );

    modport slave (
        input  addr, ren, wen, wmask, wdata,
        output rdata
    );

    modport master_rdonly (
        output addr, ren,
        input  rdata
    );

    modport master_wronly (
        output addr, wen, wmask, wdata
    );

endinterface

// File: rtl/bus_addr_decoder.sv
// Combinational address decode: which window the CPU address hits, what the
// read-data steering should register, and whether the access has no valid target.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [31:0] ROM_BASE   = DEF_ROM_BASE,
    parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
    parameter logic [31:0] UART_BASE  = DEF_UART_BASE
) (
    input  logic [31:0] addr,
    input  logic        ren,
    input  logic        wen,
    output bus_sel_e    hit,
    output bus_sel_e    rd_sel,
    output logic        unmapped
);

    localparam logic [31:0] MEM_SIZE = 32'd4 << ADDR_WIDTH;

    always_comb begin
        hit = SEL_NONE;
        if (win_hit(addr, ROM_BASE, MEM_SIZE)) begin
            hit = SEL_ROM;
        end else if (win_hit(addr, RAM_BASE, MEM_SIZE)) begin
            hit = SEL_RAM;
        end else if (win_hit(addr, UART_BASE, UART_SIZE)) begin
            hit = SEL_UART;
        end
    end

    // A write always wins over a simultaneous read, so such a cycle returns no data.
    always_comb begin
        rd_sel = SEL_NONE;
        if (ren && !wen) begin
            rd_sel = hit;
        end
    end

    // ROM has no write path on this port, so a ROM write counts as having no target.
    always_comb begin
        unmapped = 1'b0;
        if (ren || wen) begin
            unmapped = (hit == SEL_NONE) || (wen && (hit == SEL_ROM));
        end
    end

endmodule

// File: rtl/soc_bus_controller.sv
// CPU data-side interconnect: routes strobes to ROM, RAM or UART and steers
// the registered selection back onto cpu_rdata one cycle later.
module soc_bus_controller
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [31:0] ROM_BASE   = DEF_ROM_BASE,
    parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
    parameter logic [31:0] UART_BASE  = DEF_UART_BASE
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [31:0]           cpu_addr,
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    input  logic [3:0]            cpu_wmask,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_err,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_ren,
    output logic                  ram_wen,
    output logic [3:0]            ram_wmask,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,

    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ren,
    input  logic [31:0]           rom_rdata,

    output logic [1:0]            uart_addr,
    output logic                  uart_ren,
    output logic                  uart_wen,
    output logic [3:0]            uart_wmask,
    output logic [31:0]           uart_wdata,
    input  logic [31:0]           uart_rdata
);

    bus_if #(.AW(32))         cpu_bus ();
    bus_if #(.AW(ADDR_WIDTH)) rom_bus ();
    bus_if #(.AW(ADDR_WIDTH)) ram_bus ();
    bus_if #(.AW(2))          uart_bus ();

    bus_sel_e hit;
    bus_sel_e rd_sel;
    logic     unmapped;
    bus_sel_e sel_q;
    logic     err_q;
    logic     acc_ren;
    logic     acc_wen;
    logic     unused_rom_wr;

    assign cpu_bus.addr  = cpu_addr;
    assign cpu_bus.ren   = cpu_ren;
    assign cpu_bus.wen   = cpu_wen;
    assign cpu_bus.wmask = cpu_wmask;
    assign cpu_bus.wdata = cpu_wdata;

    bus_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ROM_BASE   (ROM_BASE),
        .RAM_BASE   (RAM_BASE),
        .UART_BASE  (UART_BASE)
    ) u_decoder (
        .addr     (cpu_bus.addr),
        .ren      (cpu_bus.ren),
        .wen      (cpu_bus.wen),
        .hit      (hit),
        .rd_sel   (rd_sel),
        .unmapped (unmapped)
    );

    // Strobes are held off during reset regardless of what the CPU drives.
    assign acc_ren = cpu_bus.ren & ~cpu_bus.wen & ~rst;
    assign acc_wen = cpu_bus.wen & ~rst;

    assign rom_bus.addr  = cpu_bus.addr[ADDR_WIDTH+1:2];
    assign rom_bus.ren   = acc_ren & (hit == SEL_ROM);
    assign rom_bus.wen   = 1'b0;
    assign rom_bus.wmask = cpu_bus.wmask;
    assign rom_bus.wdata = cpu_bus.wdata;
    assign rom_bus.rdata = rom_rdata;

    assign ram_bus.addr  = cpu_bus.addr[ADDR_WIDTH+1:2];
    assign ram_bus.ren   = acc_ren & (hit == SEL_RAM);
    assign ram_bus.wen   = acc_wen & (hit == SEL_RAM);
    assign ram_bus.wmask = cpu_bus.wmask;
    assign ram_bus.wdata = cpu_bus.wdata;
    assign ram_bus.rdata = ram_rdata;

    assign uart_bus.addr  = cpu_bus.addr[3:2];
    assign uart_bus.ren   = acc_ren & (hit == SEL_UART);
    assign uart_bus.wen   = acc_wen & (hit == SEL_UART);
    assign uart_bus.wmask = cpu_bus.wmask;
    assign uart_bus.wdata = cpu_bus.wdata;
    assign uart_bus.rdata = uart_rdata;

    // The ROM port has no write side; these broadcast lines go nowhere.
    assign unused_rom_wr = ^{rom_bus.wen, rom_bus.wmask, rom_bus.wdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= SEL_NONE;
            err_q <= 1'b0;
        end else begin
            sel_q <= rd_sel;
            err_q <= unmapped;
        end
    end

    // Each cycle's read data follows the selection registered for it, so
    // back-to-back reads to different slaves steer correctly.
    always_comb begin
        cpu_bus.rdata = 32'h0;
        case (sel_q)
            SEL_ROM:  cpu_bus.rdata = rom_bus.rdata;
            SEL_RAM:  cpu_bus.rdata = ram_bus.rdata;
            SEL_UART: cpu_bus.rdata = uart_bus.rdata;
            default:  cpu_bus.rdata = 32'h0;
        endcase
    end

    assign cpu_rdata = cpu_bus.rdata;
    assign cpu_err   = err_q;

    assign rom_addr   = rom_bus.addr;
    assign rom_ren    = rom_bus.ren;

    assign ram_addr   = ram_bus.addr;
    assign ram_ren    = ram_bus.ren;
    assign ram_wen    = ram_bus.wen;
    assign ram_wmask  = ram_bus.wmask;
    assign ram_wdata  = ram_bus.wdata;

    assign uart_addr  = uart_bus.addr;
    assign uart_ren   = uart_bus.ren;
    assign uart_wen   = uart_bus.wen;
    assign uart_wmask = uart_bus.wmask;
    assign uart_wdata = uart_bus.wdata;

endmodule

// File: tb/tb_soc_bus_controller.sv
// Directed bench for soc_bus_controller with behavioural ROM/RAM/UART slaves;
// expected read data and error flags are queued at drive time and popped after the edge.
module tb_soc_bus_controller;

    logic clk = 1'b0;
    logic rst;
    logic cpu_err;

    always #5 clk = ~clk;

    bus_if #(.AW(32)) cpu ();
    bus_if #(.AW(14)) ram ();
    bus_if #(.AW(14)) rom ();
    bus_if #(.AW(2))  uart ();

    soc_bus_controller dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu.addr),
        .cpu_ren    (cpu.ren),
        .cpu_wen    (cpu.wen),
        .cpu_wmask  (cpu.wmask),
        .cpu_wdata  (cpu.wdata),
        .cpu_rdata  (cpu.rdata),
        .cpu_err    (cpu_err),
        .ram_addr   (ram.addr),
        .ram_ren    (ram.ren),
        .ram_wen    (ram.wen),
        .ram_wmask  (ram.wmask),
        .ram_wdata  (ram.wdata),
        .ram_rdata  (ram.rdata),
        .rom_addr   (rom.addr),
        .rom_ren    (rom.ren),
        .rom_rdata  (rom.rdata),
        .uart_addr  (uart.addr),
        .uart_ren   (uart.ren),
        .uart_wen   (uart.wen),
        .uart_wmask (uart.wmask),
        .uart_wdata (uart.wdata),
        .uart_rdata (uart.rdata)
    );

    // Synchronous slave models: data appears the cycle after the read strobe.
    logic [31:0] ram_mem [0:15];

    initial begin
        for (int i = 0; i < 16; i++) ram_mem[i] = 32'h0;
        rom.rdata  = 32'h0;
        ram.rdata  = 32'h0;
        uart.rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (rom.ren)  rom.rdata  <= 32'hC0DE_0000 | 32'(rom.addr);
        if (uart.ren) uart.rdata <= 32'h5A00_0000 | 32'(uart.addr);
        if (ram.ren)  ram.rdata  <= ram_mem[ram.addr[3:0]];
        if (ram.wen) begin
            for (int b = 0; b < 4; b++) begin
                if (ram.wmask[b]) ram_mem[ram.addr[3:0]][8*b +: 8] <= ram.wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // estrb = {rom_ren, ram_ren, ram_wen, uart_ren, uart_wen}
    task automatic access(input string tag, input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [3:0] m, input logic [31:0] d,
                          input logic [4:0] estrb, input logic [31:0] esaddr,
                          input logic [31:0] erdata, input logic eerr);
        exp_t e;
        logic [4:0] strb;
        cpu.ren   = ren;
        cpu.wen   = wen;
        cpu.addr  = addr;
        cpu.wmask = m;
        cpu.wdata = d;
        sb.push_back('{erdata, eerr});
        #1;
        strb = {rom.ren, ram.ren, ram.wen, uart.ren, uart.wen};
        chk({tag, ".strb"}, 32'(strb), 32'(estrb));
        if (estrb[4])            chk({tag, ".rom_addr"},  32'(rom.addr),  esaddr);
        if (estrb[3] | estrb[2]) chk({tag, ".ram_addr"},  32'(ram.addr),  esaddr);
        if (estrb[1] | estrb[0]) chk({tag, ".uart_addr"}, 32'(uart.addr), esaddr);
        if (estrb[2])            chk({tag, ".ram_wmask"}, 32'(ram.wmask), 32'(m));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".rdata"}, cpu.rdata, e.rdata);
            chk({tag, ".err"},   32'(cpu_err), 32'(e.err));
        end
        $display("[TB] %-12s ren=%b wen=%b addr=%h strb=%b rdata=%h err=%b",
                 tag, ren, wen, addr, strb, cpu.rdata, cpu_err);
    endtask

    initial begin
        rst       = 1'b1;
        cpu.ren   = 1'b1;
        cpu.wen   = 1'b0;
        cpu.addr  = 32'h1000_0004;
        cpu.wmask = 4'h0;
        cpu.wdata = 32'h0;

        // Reset held with a live read request: everything quiet.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.strb",  32'({rom.ren, ram.ren, ram.wen, uart.ren, uart.wen}), 32'd0);
        chk("rst.rdata", cpu.rdata, 32'h0);
        chk("rst.err",   32'(cpu_err), 32'd0);
        $display("[TB] reset       ren=1 addr=%h rdata=%h err=%b", cpu.addr, cpu.rdata, cpu_err);

        rst = 1'b0;
        #1;
        chk("rel.ram_ren", 32'(ram.ren), 32'd1);
        @(posedge clk);
        #1;
        chk("rel.rdata", cpu.rdata, 32'h0);
        $display("[TB] release     ram_ren decoded, rdata=%h", cpu.rdata);

        access("ram_wr",   1'b0, 1'b1, 32'h1000_0004, 4'b0011, 32'hDEAD_BEEF, 5'b00100, 32'd1,     32'h0,         1'b0);
        access("ram_rd",   1'b1, 1'b0, 32'h1000_0004, 4'h0,    32'h0,         5'b01000, 32'd1,     32'h0000_BEEF, 1'b0);
        access("rom_rd",   1'b1, 1'b0, 32'h0000_FFFC, 4'h0,    32'h0,         5'b10000, 32'h3FFF,  32'hC0DE_3FFF, 1'b0);
        access("rom_wr",   1'b0, 1'b1, 32'h0000_0000, 4'hF,    32'h1111_2222, 5'b00000, 32'd0,     32'h0,         1'b1);
        access("uart_wr",  1'b0, 1'b1, 32'h2000_0008, 4'h1,    32'h0000_0041, 5'b00001, 32'd2,     32'h0,         1'b0);
        access("uart_oob", 1'b1, 1'b0, 32'h2000_0010, 4'h0,    32'h0,         5'b00000, 32'd0,     32'h0,         1'b1);

        access("b2b_rom",  1'b1, 1'b0, 32'h0000_0010, 4'h0,    32'h0,         5'b10000, 32'd4,     32'hC0DE_0004, 1'b0);
        access("b2b_ram",  1'b1, 1'b0, 32'h1000_0004, 4'h0,    32'h0,         5'b01000, 32'd1,     32'h0000_BEEF, 1'b0);
        access("b2b_uart", 1'b1, 1'b0, 32'h2000_000C, 4'h0,    32'h0,         5'b00010, 32'd3,     32'h5A00_0003, 1'b0);
        access("b2b_none", 1'b0, 1'b0, 32'h2000_000C, 4'h0,    32'h0,         5'b00000, 32'd0,     32'h0,         1'b0);

        access("rw_both",  1'b1, 1'b1, 32'h1000_0008, 4'hF,    32'h1234_5678, 5'b00100, 32'd2,     32'h0,         1'b0);
        access("rw_check", 1'b1, 1'b0, 32'h1000_0008, 4'h0,    32'h0,         5'b01000, 32'd2,     32'h1234_5678, 1'b0);

        access("rom_top",  1'b1, 1'b0, 32'h0000_FFFF, 4'h0,    32'h0,         5'b10000, 32'h3FFF,  32'hC0DE_3FFF, 1'b0);
        access("rom_end",  1'b1, 1'b0, 32'h0001_0000, 4'h0,    32'h0,         5'b00000, 32'd0,     32'h0,         1'b1);
        access("ram_end",  1'b0, 1'b1, 32'h1001_0000, 4'hF,    32'hFFFF_FFFF, 5'b00000, 32'd0,     32'h0,         1'b1);
        access("uart_top", 1'b1, 1'b0, 32'h2000_000F, 4'h0,    32'h0,         5'b00010, 32'd3,     32'h5A00_0003, 1'b0);
        access("no_win",   1'b1, 1'b0, 32'h3000_0000, 4'h0,    32'h0,         5'b00000, 32'd0,     32'h0,         1'b1);
        access("ram_tail", 1'b1, 1'b0, 32'h1000_0008, 4'h0,    32'h0,         5'b01000, 32'd2,     32'h1234_5678, 1'b0);

        // Asynchronous reset mid-run with a read pending.
        cpu.ren  = 1'b1;
        cpu.wen  = 1'b0;
        cpu.addr = 32'h0000_0010;
        rst      = 1'b1;
        #1;
        chk("arst.strb",  32'({rom.ren, ram.ren, ram.wen, uart.ren, uart.wen}), 32'd0);
        chk("arst.rdata", cpu.rdata, 32'h0);
        chk("arst.err",   32'(cpu_err), 32'd0);
        $display("[TB] async_rst   rdata=%h err=%b", cpu.rdata, cpu_err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
